// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared constants and types for the immediate-extender arbiter
package imm_ext_pkg;
  localparam int NB_IMM_DEF  = 16;
  localparam int NB_DATA_DEF = 32;
  localparam int NB_MODE_DEF = 2;
  localparam logic [1:0] EXT_MODE_SIGN    = 2'b00;
  localparam logic [1:0] EXT_MODE_ZERO    = 2'b01;
  localparam logic [1:0] EXT_MODE_UPPER   = 2'b10;
  localparam logic [1:0] EXT_MODE_ILLEGAL = 2'b11;
  typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;
endpackage

// File: rtl/imm_rr_pick.sv
// imm_rr_pick: combinational round-robin one-hot picker
// Ports: req (request vector), ptr (start position) -> grant (one-hot), idx (granted index), any (some grant)
module imm_rr_pick #(
  parameter int N  = 2,
  parameter int NB = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [NB-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [NB-1:0] idx,
  output logic          any
);
  int j;
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    j = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (req[j] && !any) begin
        grant[j] = 1'b1;
        idx = NB'(j);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin sharing of one immediate extender with a one-entry result buffer
// Ports: i_clk, i_reset (sync, active-low); per-requester i_req_valid/i_req_imm/i_req_mode/o_req_ready;
//   extender side o_ext_signal/o_ext_mode/i_ext_result; result side o_res_valid/o_res_data/o_res_id/o_res_err/i_res_ready.
// Option: IMM_EXT_DEBUG_PRIO_EN gives requester N_REQ-1 strict priority; round-robin covers the rest.
module imm_ext_arbiter
  import imm_ext_pkg::*;
#(
  parameter int NB_IMM  = NB_IMM_DEF,
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_MODE = NB_MODE_DEF,
  parameter int N_REQ   = 2,
  parameter int NB_ID   = $clog2(N_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*NB_IMM-1:0]  i_req_imm,
  input  logic [N_REQ*NB_MODE-1:0] i_req_mode,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic [NB_IMM-1:0]        o_ext_signal,
  output logic [NB_MODE-1:0]       o_ext_mode,
  input  logic [NB_DATA-1:0]       i_ext_result,
  output logic                     o_res_valid,
  output logic [NB_DATA-1:0]       o_res_data,
  output logic [NB_ID-1:0]         o_res_id,
  output logic                     o_res_err,
  input  logic                     i_res_ready
);
  buf_state_t state, state_nx;
  logic [NB_ID-1:0] ptr, ptr_nx, pick_idx, idx;
  logic [N_REQ-1:0] pick_req, pick_grant, grant;
  logic pick_any, any, can_take, accept, err_nx;
  imm_rr_pick #(.N(N_REQ), .NB(NB_ID)) u_pick (
    .req(pick_req), .ptr(ptr), .grant(pick_grant), .idx(pick_idx), .any(pick_any)
  );
`ifdef IMM_EXT_DEBUG_PRIO_EN
  logic dbg;
  // debug requester is masked out of the rotation and overrides it whenever valid
  assign dbg = i_req_valid[N_REQ-1];
  assign pick_req = {1'b0, i_req_valid[N_REQ-2:0]};
  assign grant = dbg ? {1'b1, {(N_REQ-1){1'b0}}} : pick_grant;
  assign idx = dbg ? NB_ID'(N_REQ-1) : pick_idx;
  assign any = dbg | pick_any;
  assign ptr_nx = dbg ? ptr : (pick_idx == NB_ID'(N_REQ-2) ? '0 : pick_idx + 1'b1);
`else
  assign pick_req = i_req_valid;
  assign grant = pick_grant;
  assign idx = pick_idx;
  assign any = pick_any;
  assign ptr_nx = idx == NB_ID'(N_REQ-1) ? '0 : idx + 1'b1;
`endif
  assign o_res_valid = state == BUF_FULL;
  assign can_take = ~o_res_valid | i_res_ready;
  assign o_req_ready = i_reset ? (grant & {N_REQ{can_take}}) : '0;
  assign accept = any & can_take & i_reset;
  assign o_ext_signal = any ? i_req_imm[idx*NB_IMM +: NB_IMM] : '0;
  assign o_ext_mode = any ? i_req_mode[idx*NB_MODE +: NB_MODE] : '0;
  assign err_nx = o_ext_mode == NB_MODE'(EXT_MODE_ILLEGAL);
  always_comb begin
    state_nx = accept ? BUF_FULL : (i_res_ready ? BUF_EMPTY : state);
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= BUF_EMPTY;
      o_res_data <= '0;
      o_res_id <= '0;
      o_res_err <= 1'b0;
      ptr <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        o_res_data <= err_nx ? '1 : i_ext_result;
        o_res_id <= idx;
        o_res_err <= err_nx;
        ptr <= ptr_nx;
      end
    end
  end
endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter: directed and randomized checks of imm_ext_arbiter against a behavioural model
module tb_imm_ext_arbiter;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid;
  logic [31:0] req_imm;
  logic [3:0] req_mode;
  logic [1:0] o_req_ready;
  logic [15:0] o_ext_signal;
  logic [1:0] o_ext_mode;
  logic [31:0] ext_result;
  logic o_res_valid;
  logic [31:0] o_res_data;
  logic o_res_id;
  logic o_res_err;
  logic res_ready;
  logic [34:0] res;
  int tests = 0;
  int fails = 0;
  logic m_valid;
  logic [31:0] m_data;
  logic m_id;
  logic m_err;
  int m_ptr;
  always #5 clk = ~clk;
  imm_ext_arbiter dut (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(req_valid), .i_req_imm(req_imm),
    .i_req_mode(req_mode), .o_req_ready(o_req_ready), .o_ext_signal(o_ext_signal),
    .o_ext_mode(o_ext_mode), .i_ext_result(ext_result), .o_res_valid(o_res_valid),
    .o_res_data(o_res_data), .o_res_id(o_res_id), .o_res_err(o_res_err), .i_res_ready(res_ready)
  );
  function automatic logic [31:0] ext_f(logic [15:0] imm, logic [1:0] m);
    case (m)
      2'b00: return {{16{imm[15]}}, imm};
      2'b01: return {16'h0000, imm};
      2'b10: return {imm, 16'h0000};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction
  assign ext_result = ext_f(o_ext_signal, o_ext_mode);
  assign res = {o_res_valid, o_res_data, o_res_id, o_res_err};
  function automatic int model_pick(logic [1:0] v, int p);
`ifdef IMM_EXT_DEBUG_PRIO_EN
    if (v[N-1]) return N-1;
    for (int i = 0; i < N-1; i++) if (v[(p+i)%(N-1)]) return (p+i)%(N-1);
`else
    for (int i = 0; i < N; i++) if (v[(p+i)%N]) return (p+i)%N;
`endif
    return -1;
  endfunction
  function automatic int model_next(int k, int p);
`ifdef IMM_EXT_DEBUG_PRIO_EN
    return (k == N-1) ? p : (k+1)%(N-1);
`else
    return (k+1)%N;
`endif
  endfunction
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_imm = '0;
    req_mode = '0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_valid = 1'b0;
    m_data = '0;
    m_id = 1'b0;
    m_err = 1'b0;
    m_ptr = 0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b01;
    req_imm = 32'h0000_AAAA;
    req_mode = 4'b0000;
    res_ready = 1'b1;
    repeat (3) begin
      #1;
      tests++; if (o_req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", o_req_ready); end
      @(posedge clk); #1;
      tests++; if ({o_res_valid, o_res_data} !== 33'h0) begin fails++; $display("FAIL reset_outputs: got %h want 0", {o_res_valid, o_res_data}); end
      @(negedge clk);
    end
    rst_n = 1'b1;
    #1;
    tests++; if (o_req_ready !== 2'b01) begin fails++; $display("FAIL release_ready: got %b want 01", o_req_ready); end
    @(posedge clk); #1;
    tests++; if (res !== {1'b1, 32'hFFFF_AAAA, 1'b0, 1'b0}) begin fails++; $display("FAIL release_accept: got %h want %h", res, {1'b1, 32'hFFFF_AAAA, 1'b0, 1'b0}); end
    @(negedge clk);
  endtask
  task automatic test_modes();
    logic [31:0] exp [3] = '{32'hFFFF_AAAA, 32'h0000_AAAA, 32'hAAAA_0000};
    do_reset();
    for (int m = 0; m < 3; m++) begin
      req_valid = 2'b01;
      req_imm = 32'h0000_AAAA;
      req_mode = {2'b00, 2'(m)};
      @(posedge clk); #1;
      tests++; if (res !== {1'b1, exp[m], 1'b0, 1'b0}) begin fails++; $display("FAIL mode_%0d: got %h want %h", m, res, {1'b1, exp[m], 1'b0, 1'b0}); end
      @(negedge clk);
    end
  endtask
  task automatic test_illegal();
    do_reset();
    req_valid = 2'b10;
    req_imm = 32'h1234_0000;
    req_mode = 4'b1100;
    @(posedge clk); #1;
    tests++; if (res !== {1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1}) begin fails++; $display("FAIL illegal: got %h want %h", res, {1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1}); end
    @(negedge clk);
  endtask
  task automatic test_contention();
    logic exp_id;
    do_reset();
    req_valid = 2'b11;
    req_imm = 32'h1111_2222;
    req_mode = 4'b0000;
    for (int n = 0; n < 4; n++) begin
`ifdef IMM_EXT_DEBUG_PRIO_EN
      exp_id = 1'b1;
`else
      exp_id = n[0];
`endif
      @(posedge clk); #1;
      tests++; if (o_res_id !== exp_id || o_res_valid !== 1'b1) begin fails++; $display("FAIL contention_%0d: got id %b valid %b want id %b valid 1", n, o_res_id, o_res_valid, exp_id); end
      @(negedge clk);
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    req_valid = 2'b01;
    req_imm = 32'h0000_00FF;
    req_mode = 4'b0001;
    @(posedge clk); #1;
    tests++; if (res !== {1'b1, 32'h0000_00FF, 1'b0, 1'b0}) begin fails++; $display("FAIL bp_load: got %h want %h", res, {1'b1, 32'h0000_00FF, 1'b0, 1'b0}); end
    @(negedge clk);
    res_ready = 1'b0;
    req_valid = 2'b11;
    req_imm = 32'h5555_0F0F;
    req_mode = 4'b0101;
    repeat (3) begin
      #1;
      tests++; if (o_req_ready !== 2'b00) begin fails++; $display("FAIL bp_ready: got %b want 00", o_req_ready); end
      @(posedge clk); #1;
      tests++; if (res !== {1'b1, 32'h0000_00FF, 1'b0, 1'b0}) begin fails++; $display("FAIL bp_hold: got %h want %h", res, {1'b1, 32'h0000_00FF, 1'b0, 1'b0}); end
      @(negedge clk);
    end
    res_ready = 1'b1;
    req_valid = 2'b01;
    #1;
    tests++; if (o_req_ready !== 2'b01) begin fails++; $display("FAIL b2b_ready: got %b want 01", o_req_ready); end
    @(posedge clk); #1;
    tests++; if (res !== {1'b1, 32'h0000_0F0F, 1'b0, 1'b0}) begin fails++; $display("FAIL b2b_data: got %h want %h", res, {1'b1, 32'h0000_0F0F, 1'b0, 1'b0}); end
    @(negedge clk);
  endtask
  task automatic test_reset_full();
    logic [1:0] exp_rdy;
    do_reset();
    req_valid = 2'b01;
    req_imm = 32'h0000_00FF;
    req_mode = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    req_valid = 2'b10;
    rst_n = 1'b0;
    #1;
    tests++; if (o_req_ready !== 2'b00) begin fails++; $display("FAIL rf_ready: got %b want 00", o_req_ready); end
    @(posedge clk); #1;
    tests++; if (res !== 35'h0) begin fails++; $display("FAIL rf_clear: got %h want 0", res); end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b11;
    res_ready = 1'b1;
`ifdef IMM_EXT_DEBUG_PRIO_EN
    exp_rdy = 2'b10;
`else
    exp_rdy = 2'b01;
`endif
    #1;
    tests++; if (o_req_ready !== exp_rdy) begin fails++; $display("FAIL rf_winner: got %b want %b", o_req_ready, exp_rdy); end
    @(posedge clk); #1;
    tests++; if (o_res_id !== exp_rdy[1] || o_res_valid !== 1'b1) begin fails++; $display("FAIL rf_result: got id %b valid %b want id %b valid 1", o_res_id, o_res_valid, exp_rdy[1]); end
    @(negedge clk);
  endtask
  task automatic test_random();
    int k;
    logic can;
    logic [1:0] exp_rdy;
    logic [15:0] imm_k;
    logic [1:0] mode_k;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      req_valid = 2'($urandom);
      req_imm = $urandom;
      req_mode = 4'($urandom);
      res_ready = ($urandom_range(3) != 0);
      #1;
      k = model_pick(req_valid, m_ptr);
      can = !m_valid || res_ready;
      imm_k = (k >= 0) ? req_imm[k*16 +: 16] : 16'h0;
      mode_k = (k >= 0) ? req_mode[k*2 +: 2] : 2'b00;
      exp_rdy = (k >= 0 && can) ? 2'(1 << k) : 2'b00;
      tests++; if (o_req_ready !== exp_rdy) begin fails++; $display("FAIL rand_ready[%0d]: got %b want %b", n, o_req_ready, exp_rdy); end
      tests++; if ({o_ext_signal, o_ext_mode} !== {imm_k, mode_k}) begin fails++; $display("FAIL rand_ext[%0d]: got %h/%b want %h/%b", n, o_ext_signal, o_ext_mode, imm_k, mode_k); end
      if (k >= 0 && can) begin
        m_valid = 1'b1;
        m_data = ext_f(imm_k, mode_k);
        m_id = k[0];
        m_err = mode_k == 2'b11;
        m_ptr = model_next(k, m_ptr);
      end else if (res_ready) m_valid = 1'b0;
      @(posedge clk); #1;
      tests++; if (res !== {m_valid, m_data, m_id, m_err}) begin fails++; $display("FAIL rand_res[%0d]: got %h want %h", n, res, {m_valid, m_data, m_id, m_err}); end
      @(negedge clk);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_imm = '0;
    req_mode = '0;
    res_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_modes();
    test_illegal();
    test_contention();
    test_back_to_back();
    test_reset_full();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
